// File: rtl/instr_fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_buffer_pkg
// Purpose : Shared pipeline definitions for fetch/decode: datapath width,
//           the canonical NOP and the {pc, instr} fetch packet reused by the
//           IF/ID register and decode.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package instr_fetch_buffer_pkg;

    localparam int          XLEN      = 32;
    // addi x0, x0, 0 -- the architectural NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage : instr_fetch_buffer_pkg
`default_nettype wire

// File: rtl/instr_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_buffer_if
// Purpose : Handshake bundle between fetch (push side), the fetch buffer and
//           decode (pop side), plus the redirect flush and occupancy.
// Ports   : flush, in_valid/in_ready/in_pc/in_instr,
//           out_valid/out_ready/out_pc/out_instr, count
//           modport slave  -> the buffer itself
//           modport master -> the environment driving/consuming it
// Rev     : 1.0  initial release
// ============================================================================
interface instr_fetch_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) ();

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [XLEN-1:0]        in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_instr;
    logic [$clog2(DEPTH):0] count;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

endinterface : instr_fetch_buffer_if
`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_buffer
// Purpose : DEPTH-entry circular queue of {pc, instr} between instruction
//           fetch and decode. Valid/ready on both sides, flush on redirect,
//           NOP presented when empty. All outputs come from registered state.
// Ports   : clk  - pipeline clock
//           rst  - synchronous active-high reset (priority over flush)
//           bus  - instr_fetch_buffer_if.slave (handshakes, flush, count)
// Rev     : 1.0  initial release
// ============================================================================
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter int          XLEN      = instr_fetch_buffer_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = instr_fetch_buffer_pkg::NOP_INSTR
) (
    input  wire                   clk,
    input  wire                   rst,
    instr_fetch_buffer_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_EMPTY = '0;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [XLEN-1:0]  pc_mem_d    [DEPTH];
    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  instr_mem_d [DEPTH];

    logic w_push;
    logic w_pop;

    // Ready is derived only from occupancy; a full buffer never lets a word
    // through on the strength of a same-cycle pop.
    assign bus.in_ready  = (count_q != C_FULL);
    assign bus.out_valid = (count_q != C_EMPTY);
    assign bus.count     = count_q;
    assign bus.out_pc    = bus.out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign bus.out_instr = bus.out_valid ? instr_mem_q[rd_ptr_q] : XLEN'(NOP_INSTR);

    assign w_push = bus.in_valid  & bus.in_ready  & ~bus.flush;
    assign w_pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                pc_mem_d[wr_ptr_q]    = bus.in_pc;
                instr_mem_d[wr_ptr_q] = bus.in_instr;
                // DEPTH is a power of two, so natural overflow wraps the pointer
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: entries are only ever read while counted valid.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule : instr_fetch_buffer
`default_nettype wire
